// File: rtl/node_share_sched_if.sv
// Bundle of the requester-facing and node-facing signals of the shared-node scheduler.
// The master modport is the scheduler's view; the slave modport is the environment's.
interface node_share_sched_if #(
    parameter int unsigned NReq  = 4,
    parameter int unsigned Width = 16
);
    logic [NReq-1:0]       req;
    logic [NReq*Width-1:0] arg0;
    logic [NReq*Width-1:0] arg1;
    logic [NReq-1:0]       gnt;
    logic [NReq-1:0]       done;
    logic [Width-1:0]      res;
    logic                  err;
    logic                  busy;
    logic                  node_st;
    logic [Width-1:0]      node_in0;
    logic [Width-1:0]      node_in1;
    logic                  node_rd;
    logic [Width-1:0]      node_res;

    modport master (
        input  req, arg0, arg1, node_rd, node_res,
        output gnt, done, res, err, busy, node_st, node_in0, node_in1
    );

    modport slave (
        output req, arg0, arg1, node_rd, node_res,
        input  gnt, done, res, err, busy, node_st, node_in0, node_in1
    );
endinterface

// File: rtl/node_share_sched.sv
// Round-robin scheduler sharing one ST/RD/RES evaluation node between NReq requesters,
// with start pulse generation, ready tracking and ack/done timeouts.
module node_share_sched #(
    parameter int unsigned NReq   = 4,
    parameter int unsigned Width  = 16,
    parameter int unsigned StLen  = 2,
    parameter int unsigned AckTo  = 16,
    parameter int unsigned DoneTo = 65535
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    node_share_sched_if.master bus_io
);
    localparam int unsigned IdxW = $clog2(NReq);
    localparam logic [NReq-1:0] OneHot0 = NReq'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitAck,
        StWaitDone,
        StFinish
    } state_e;

    state_e            state_q;
    logic [NReq-1:0]   gnt_q;
    logic [NReq-1:0]   done_q;
    logic              err_q;
    logic              st_q;
    logic [Width-1:0]  res_q;
    logic [Width-1:0]  in0_q;
    logic [Width-1:0]  in1_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   own_q;
    logic [15:0]       cnt_q;

    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;
    int unsigned       cand;
    logic [15:0]       cnt_inc;
    logic [IdxW-1:0]   ptr_next;

    // First requester at or after the pointer, wrapping at NReq-1.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NReq; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NReq) begin
                cand = cand - NReq;
            end
            if (!pick_vld && bus_io.req[IdxW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        ptr_next = (32'(own_q) == NReq - 1) ? '0 : own_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            st_q    <= 1'b0;
            res_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.node_rd && pick_vld) begin
                        gnt_q   <= OneHot0 << pick_idx;
                        own_q   <= pick_idx;
                        in0_q   <= bus_io.arg0[32'(pick_idx) * Width +: Width];
                        in1_q   <= bus_io.arg1[32'(pick_idx) * Width +: Width];
                        st_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == 16'(StLen - 1)) begin
                        st_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StWaitAck;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StWaitAck: begin
                    if (!bus_io.node_rd) begin
                        cnt_q   <= '0;
                        state_q <= StWaitDone;
                    end else if (cnt_q == 16'(AckTo - 1)) begin
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StWaitDone: begin
                    // Entry required RD sampled low, so RD high here is the rising edge.
                    if (bus_io.node_rd) begin
                        res_q   <= bus_io.node_res;
                        done_q  <= gnt_q;
                        state_q <= StFinish;
                    end else if (cnt_q == 16'(DoneTo - 1)) begin
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StFinish: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    ptr_q   <= ptr_next;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.gnt      = gnt_q;
    assign bus_io.done     = done_q;
    assign bus_io.res      = res_q;
    assign bus_io.err      = err_q;
    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.node_st  = st_q;
    assign bus_io.node_in0 = in0_q;
    assign bus_io.node_in1 = in1_q;
endmodule

// File: tb/tb_node_share_sched.sv
// Self-checking bench for node_share_sched: behavioural node model plus an ordered
// scoreboard of expected DONE owner/result/error, checked whenever DONE pulses.
module tb_node_share_sched;
    localparam int unsigned NReq    = 4;
    localparam int unsigned Width   = 16;
    localparam int unsigned StLen   = 2;
    localparam int unsigned AckTo   = 16;
    localparam int unsigned DoneTo  = 64;
    localparam int          BusyLen = 10;

    logic clk;
    logic rst_n;

    node_share_sched_if #(.NReq(NReq), .Width(Width)) nif ();

    node_share_sched #(
        .NReq  (NReq),
        .Width (Width),
        .StLen (StLen),
        .AckTo (AckTo),
        .DoneTo(DoneTo)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(nif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NReq-1:0]  owner;
        logic [Width-1:0] res;
        logic             err;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               errors = 0;
    int               checks = 0;
    logic [Width-1:0] last_res;
    int               node_mode;  // 0 normal, 1 never acks, 2 never finishes
    int               busy_len;
    logic             nm_busy;
    int               nm_cnt;
    logic [Width-1:0] nm_a;
    logic [Width-1:0] nm_b;

    function automatic logic [Width-1:0] node_fn(input logic [Width-1:0] a,
                                                 input logic [Width-1:0] b);
        return a * (b + b) + b;
    endfunction

    // Behavioural shared node: drops RD the cycle after it sees ST, raises it with a result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nif.node_rd  <= 1'b1;
            nif.node_res <= '0;
            nm_busy      <= 1'b0;
            nm_cnt       <= 0;
            nm_a         <= '0;
            nm_b         <= '0;
        end else if (!nm_busy) begin
            if (nif.node_st && nif.node_rd && node_mode != 1) begin
                nm_busy     <= 1'b1;
                nif.node_rd <= 1'b0;
                nm_cnt      <= 0;
                nm_a        <= nif.node_in0;
                nm_b        <= nif.node_in1;
            end
        end else if (node_mode == 0) begin
            if (nm_cnt >= busy_len - 1) begin
                nif.node_rd  <= 1'b1;
                nif.node_res <= node_fn(nm_a, nm_b);
                nm_busy      <= 1'b0;
            end else begin
                nm_cnt <= nm_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && nif.done != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=%b with nothing outstanding", nif.done);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (nif.done !== mon_e.owner) begin
                    errors++;
                    $display("FAIL done_owner: got %b expected %b", nif.done, mon_e.owner);
                end
                checks++;
                if (nif.gnt !== mon_e.owner) begin
                    errors++;
                    $display("FAIL gnt_at_done: got %b expected %b", nif.gnt, mon_e.owner);
                end
                checks++;
                if (nif.res !== mon_e.res) begin
                    errors++;
                    $display("FAIL res: got %h expected %h", nif.res, mon_e.res);
                end
                checks++;
                if (nif.err !== mon_e.err) begin
                    errors++;
                    $display("FAIL err: got %b expected %b", nif.err, mon_e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push_exp(input int idx, input logic [Width-1:0] res, input logic err);
        exp_t e;
        e.owner      = '0;
        e.owner[idx] = 1'b1;
        e.res        = err ? last_res : res;
        e.err        = err;
        if (!err) last_res = res;
        sb.push_back(e);
    endtask

    task automatic set_args(input int idx, input logic [Width-1:0] a, input logic [Width-1:0] b);
        nif.arg0[idx*Width +: Width] = a;
        nif.arg1[idx*Width +: Width] = b;
    endtask

    task automatic wait_done(input int idx, input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (nif.done[idx]) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        nif.req  = '0;
        node_mode = 0;
        busy_len  = BusyLen;
        sb.delete();
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        nif.req   = '0;
        nif.arg0  = '0;
        nif.arg1  = '0;
        node_mode = 0;
        busy_len  = BusyLen;
        last_res  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (nif.gnt !== '0 || nif.done !== '0) begin
            errors++;
            $display("FAIL reset_gnt_done: got gnt=%b done=%b expected 0", nif.gnt, nif.done);
        end
        checks++;
        if (nif.err !== 1'b0 || nif.busy !== 1'b0 || nif.node_st !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got err=%b busy=%b st=%b expected 0",
                     nif.err, nif.busy, nif.node_st);
        end
        checks++;
        if (nif.res !== '0 || nif.node_in0 !== '0 || nif.node_in1 !== '0) begin
            errors++;
            $display("FAIL reset_data: got res=%h in0=%h in1=%h expected 0",
                     nif.res, nif.node_in0, nif.node_in1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int cyc;
        set_args(0, 16'd5, 16'd3);
        nif.req = 4'b0001;
        push_exp(0, 16'h0021, 1'b0);
        @(negedge clk);
        checks++;
        if (nif.gnt !== 4'b0001 || nif.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b busy=%b expected 0001 1", nif.gnt, nif.busy);
        end
        checks++;
        if (nif.node_st !== 1'b1 || nif.node_in0 !== 16'd5 || nif.node_in1 !== 16'd3) begin
            errors++;
            $display("FAIL single_start: got st=%b in0=%h in1=%h expected 1 0005 0003",
                     nif.node_st, nif.node_in0, nif.node_in1);
        end
        @(negedge clk);
        checks++;
        if (nif.node_st !== 1'b1) begin
            errors++;
            $display("FAIL st_second_cycle: got %b expected 1", nif.node_st);
        end
        @(negedge clk);
        checks++;
        if (nif.node_st !== 1'b0) begin
            errors++;
            $display("FAIL st_fall: got %b expected 0", nif.node_st);
        end
        wait_done(0, 100, cyc);
        nif.req = '0;
        checks++;
        if (cyc < 0 || cyc + 2 !== 1 + BusyLen + 1) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles expected %0d", cyc + 2, BusyLen + 2);
        end
        @(negedge clk);
        checks++;
        if (nif.gnt !== '0 || nif.busy !== 1'b0 || nif.res !== 16'h0021) begin
            errors++;
            $display("FAIL single_after: got gnt=%b busy=%b res=%h expected 0000 0 0021",
                     nif.gnt, nif.busy, nif.res);
        end
    endtask

    task automatic test_contention;
        int cyc;
        int gap;
        do_reset();
        for (int i = 0; i < 4; i++) set_args(i, 16'(100 + i * 7), 16'(i + 2));
        for (int k = 0; k < 8; k++) push_exp(k % 4, node_fn(16'(100 + (k % 4) * 7), 16'(k % 4 + 2)), 1'b0);
        nif.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_done(k % 4, 200, cyc);
            checks++;
            if (cyc < 0) begin
                errors++;
                $display("FAIL contention_timeout: op %0d got no done expected owner %0d", k, k % 4);
            end
            if (k == 7) begin
                nif.req = '0;
            end else begin
                gap = -1;
                for (int c = 1; c <= 5; c++) begin
                    @(negedge clk);
                    if (nif.gnt != '0) begin
                        gap = c;
                        break;
                    end
                end
                checks++;
                if (gap !== 2) begin
                    errors++;
                    $display("FAIL contention_gap: got %0d cycles expected 2", gap);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stuck_ack;
        int cyc;
        node_mode = 1;
        set_args(2, 16'h1234, 16'd2);
        nif.req = 4'b0100;
        push_exp(2, '0, 1'b1);
        @(negedge clk);
        checks++;
        if (nif.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL stuck_grant: got %b expected 0100", nif.gnt);
        end
        wait_done(2, 100, cyc);
        checks++;
        if (cyc !== StLen + AckTo) begin
            errors++;
            $display("FAIL stuck_latency: got %0d expected %0d", cyc, StLen + AckTo);
        end
        node_mode = 0;
        set_args(3, 16'd9, 16'd4);
        nif.req = 4'b1000;
        push_exp(3, node_fn(16'd9, 16'd4), 1'b0);
        wait_done(3, 100, cyc);
        nif.req = '0;
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL stuck_next_served: got no done expected owner 3");
        end
        @(negedge clk);
    endtask

    task automatic test_hung;
        int cyc;
        node_mode = 2;
        set_args(0, 16'h0777, 16'd1);
        nif.req = 4'b0001;
        push_exp(0, '0, 1'b1);
        @(negedge clk);
        wait_done(0, 200, cyc);
        nif.req = '0;
        checks++;
        if (cyc !== StLen + 1 + DoneTo) begin
            errors++;
            $display("FAIL hung_latency: got %0d expected %0d", cyc, StLen + 1 + DoneTo);
        end
        nif.req = 4'b0010;
        repeat (6) @(negedge clk);
        checks++;
        if (nif.gnt !== '0 || nif.busy !== 1'b0) begin
            errors++;
            $display("FAIL no_grant_rd_low: got gnt=%b busy=%b expected 0000 0", nif.gnt, nif.busy);
        end
        nif.req = '0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        do_reset();
        busy_len = 30;
        set_args(1, 16'd11, 16'd2);
        nif.req = 4'b0010;
        push_exp(1, node_fn(16'd11, 16'd2), 1'b0);
        wait_done(1, 100, cyc);
        nif.req = '0;
        @(negedge clk);
        set_args(2, 16'd12, 16'd3);
        nif.req = 4'b0100;
        push_exp(2, node_fn(16'd12, 16'd3), 1'b0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (nif.gnt !== '0 || nif.done !== '0 || nif.busy !== 1'b0 || nif.node_st !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: got gnt=%b done=%b busy=%b st=%b expected 0",
                     nif.gnt, nif.done, nif.busy, nif.node_st);
        end
        checks++;
        if (nif.res !== '0 || nif.node_in0 !== '0 || nif.err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_data: got res=%h in0=%h err=%b expected 0",
                     nif.res, nif.node_in0, nif.err);
        end
        sb.delete();
        last_res  = '0;
        nif.req   = '0;
        busy_len  = BusyLen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_args(0, 16'd20, 16'd1);
        nif.req = 4'b0101;
        push_exp(0, node_fn(16'd20, 16'd1), 1'b0);
        push_exp(2, node_fn(16'd12, 16'd3), 1'b0);
        @(negedge clk);
        checks++;
        if (nif.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_after_reset: got %b expected 0001", nif.gnt);
        end
        wait_done(0, 100, cyc);
        nif.req[0] = 1'b0;
        wait_done(2, 100, cyc);
        nif.req[2] = 1'b0;
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL reset_second_served: got no done expected owner 2");
        end
        @(negedge clk);
    endtask

    task automatic test_drop_req;
        int cyc;
        set_args(3, 16'h0042, 16'h0007);
        nif.req = 4'b1000;
        push_exp(3, node_fn(16'h0042, 16'h0007), 1'b0);
        @(negedge clk);
        checks++;
        if (nif.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL drop_grant: got %b expected 1000", nif.gnt);
        end
        nif.req = '0;
        set_args(3, 16'hFFFF, 16'hFFFF);
        repeat (4) @(negedge clk);
        checks++;
        if (nif.node_in0 !== 16'h0042 || nif.node_in1 !== 16'h0007 || nif.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL drop_operands: got in0=%h in1=%h gnt=%b expected 0042 0007 1000",
                     nif.node_in0, nif.node_in1, nif.gnt);
        end
        wait_done(3, 100, cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL drop_done: got no done expected owner 3");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stuck_ack();
        test_hung();
        test_reset_mid();
        test_drop_req();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
